// File: rtl/mux2_arb_pkg.sv
// rtl/mux2_arb_pkg.sv - shared types and defaults for the two-requester mux arbiter
package mux2_arb_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Encoding matches the mux select: 1 routes data_a, 0 routes data_b.
  typedef enum logic {
    REQ_B = 1'b0,
    REQ_A = 1'b1
  } req_id_e;

endpackage

// File: rtl/mux2.sv
// rtl/mux2.sv - single-bit 2:1 mux cell, s = 1 selects a
module mux2 (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);

  assign y = s ? a : b;

endmodule

// File: rtl/mux2_bus.sv
// rtl/mux2_bus.sv - WIDTH-bit 2:1 mux built from bit-sliced mux2 cells
module mux2_bus #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic             sel,
  output logic [WIDTH-1:0] data_y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux2 u_mux2 (
      .a (data_a[i]),
      .b (data_b[i]),
      .s (sel),
      .y (data_y[i])
    );
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// rtl/mux2_rr_arbiter.sv - round-robin arbiter sharing one mux datapath, valid/ready output
// MUX2_ARB_FIXED_PRIORITY_EN: when defined, ties always go to requester A.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_b,
  output logic             select,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  arb_state_e       state_q, state_d;
  req_id_e          select_q, select_d;
  req_id_e          last_q, last_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;

  req_id_e          tie_winner;
  req_id_e          winner;
  logic             slot_free;
  logic             grant;
  logic [WIDTH-1:0] bus_y;

`ifdef MUX2_ARB_FIXED_PRIORITY_EN
  assign tie_winner = REQ_A;
`else
  assign tie_winner = (last_q == REQ_A) ? REQ_B : REQ_A;
`endif

  assign winner    = (req_a && req_b) ? tie_winner : (req_a ? REQ_A : REQ_B);
  // A held word frees its slot in the same cycle it is accepted downstream.
  assign slot_free = (state_q == IDLE) || out_ready;
  assign grant     = rst_n && slot_free && (req_a || req_b);
  assign select_d  = grant ? winner : select_q;

  mux2_bus #(
    .WIDTH (WIDTH)
  ) u_mux2_bus (
    .data_a (data_a),
    .data_b (data_b),
    .sel    (select_d),
    .data_y (bus_y)
  );

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    out_data_d = out_data_q;
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    if (grant) begin
      gnt_a      = (winner == REQ_A);
      gnt_b      = (winner == REQ_B);
      last_d     = winner;
      out_data_d = bus_y;
      state_d    = HOLD;
    end else if (state_q == HOLD && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      select_q   <= REQ_B;
      last_q     <= REQ_B;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      select_q   <= select_d;
      last_q     <= last_d;
      out_data_q <= out_data_d;
    end
  end

  assign select    = select_q;
  assign out_data  = out_data_q;
  assign out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// tb/tb_mux2_rr_arbiter.sv - randomized scoreboard bench for mux2_rr_arbiter
module tb_mux2_rr_arbiter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_a = 1'b0;
  logic [W-1:0] data_a = '0;
  logic         gnt_a;
  logic         req_b = 1'b0;
  logic [W-1:0] data_b = '0;
  logic         gnt_b;
  logic         select;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;

  mux2_rr_arbiter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .data_a    (data_a),
    .gnt_a     (gnt_a),
    .req_b     (req_b),
    .data_b    (data_b),
    .gnt_b     (gnt_b),
    .select    (select),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] word;
    logic         sel;
    int           avail;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic last_a = 1'b0;
  logic post_reset = 1'b0;
  logic m_ga, m_gb;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic exp_v;
    if (rst_n) begin
      exp_v = (q.size() > 0) && (q[0].avail <= cyc);
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
      if (exp_v) begin
        chk("out_data", {28'd0, out_data}, {28'd0, q[0].word});
        chk("select", {31'd0, select}, {31'd0, q[0].sel});
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  task automatic step(input logic ra, input logic [W-1:0] da, input logic rb,
                      input logic [W-1:0] db, input logic rdy);
    logic free, tie_a, win_a, any;
    @(posedge clk);
    #1;
    if (post_reset) begin
      chk("reset out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset out_data", {28'd0, out_data}, 32'd0);
      chk("reset select", {31'd0, select}, 32'd0);
      post_reset = 1'b0;
    end
    rst_n = 1'b1;
    req_a = ra; data_a = da; req_b = rb; data_b = db; out_ready = rdy;
    #1;
`ifdef MUX2_ARB_FIXED_PRIORITY_EN
    tie_a = 1'b1;
`else
    tie_a = !last_a;
`endif
    free  = (q.size() == 0) || rdy;
    any   = free && (ra || rb);
    win_a = ra && (!rb || tie_a);
    m_ga  = any && win_a;
    m_gb  = any && !win_a;
    chk("gnt_a", {31'd0, gnt_a}, {31'd0, m_ga});
    chk("gnt_b", {31'd0, gnt_b}, {31'd0, m_gb});
    if (any) begin
      q.push_back('{word: (win_a ? da : db), sel: win_a, avail: cyc + 1});
      last_a = win_a;
    end
  endtask

  task automatic reset_dut(input int n, input logic ra, input logic [W-1:0] da,
                           input logic rb, input logic [W-1:0] db);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (i > 0) begin
        chk("in-reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("in-reset out_data", {28'd0, out_data}, 32'd0);
      end
      rst_n = 1'b0;
      req_a = ra; data_a = da; req_b = rb; data_b = db;
      q.delete();
      last_a = 1'b0;
      #1;
      chk("in-reset gnt_a", {31'd0, gnt_a}, 32'd0);
      chk("in-reset gnt_b", {31'd0, gnt_b}, 32'd0);
    end
    post_reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         ra, rb, rdy;
    logic [W-1:0] da, db;

    reset_dut(2, 1'b1, 4'h3, 1'b1, 4'hC);
    for (int i = 0; i < 4; i++) step(1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    step(1'b0, 4'h0, 1'b1, 4'hA, 1'b1);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    step(1'b1, 4'h5, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b1, 4'h9, 1'b0);
    step(1'b0, 4'h0, 1'b1, 4'h9, 1'b1);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    step(1'b1, 4'h7, 1'b0, 4'h0, 1'b1);
    step(1'b1, 4'h6, 1'b0, 4'h0, 1'b0);
    reset_dut(1, 1'b1, 4'h6, 1'b0, 4'h0);
    step(1'b1, 4'h6, 1'b0, 4'h0, 1'b1);
    step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);

    ra = 1'b0; rb = 1'b0; da = '0; db = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_dut(1 + $urandom_range(0, 1), ra, da, rb, db);
      end
      rdy = ($urandom_range(0, 3) != 0);
      step(ra, da, rb, db, rdy);
      if (m_ga || !ra) begin
        ra = ($urandom_range(0, 3) != 0);
        da = W'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) begin
        ra = 1'b0;
      end
      if (m_gb || !rb) begin
        rb = ($urandom_range(0, 3) != 0);
        db = W'($urandom_range(0, 15));
      end else if ($urandom_range(0, 15) == 0) begin
        rb = 1'b0;
      end
    end

    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    @(negedge clk);
    #1;
    chk("drained", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
